// File: rtl/button_pkg.sv
// button_pkg: shared channel/button widths, Select encodings and encoder FSM states.
package button_pkg;

    localparam int NUM_CHANNELS = 3;
    localparam int BTN_W        = 3;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_P1   = 2'd1;
    localparam logic [1:0] SEL_P2   = 2'd2;
    localparam logic [1:0] SEL_P3   = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    // First requesting channel (1-based) after i_last, wrapping 3 -> 1; SEL_NONE if none.
    function automatic logic [1:0] rr_pick(input logic [1:0] i_last, input logic [NUM_CHANNELS-1:0] i_req);
        logic [1:0] w_pick;
        int         c;
        w_pick = SEL_NONE;
        for (int i = NUM_CHANNELS; i >= 1; i--) begin
            c = (int'(i_last) + i - 1) % NUM_CHANNELS;
            if (i_req[c]) w_pick = 2'(c + 1);
        end
        return w_pick;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: 2-flop synchroniser plus whole-vector debounce for one channel.
// o_rise flags buttons that become pressed on the edge where the stable vector updates.
module button_debouncer
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [BTN_W-1:0] i_raw,
    output logic [BTN_W-1:0] o_stable,
    output logic [BTN_W-1:0] o_rise
);

    logic [BTN_W-1:0] r_sync1;
    logic [BTN_W-1:0] r_sync2;
    logic [BTN_W-1:0] r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;
    logic             w_upd;

    assign w_diff   = r_sync2 != r_stable;
    assign w_upd    = w_diff && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign o_stable = r_stable;
    assign o_rise   = w_upd ? (r_sync2 & ~r_stable) : '0;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_upd) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/button_encoder.sv
// button_encoder: merges three debounced button channels into one Select + ButtonVector
// stream, serving pending presses round-robin over a Valid/Ready handshake.
module button_encoder
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [BTN_W-1:0] RawButtons1,
    input  logic [BTN_W-1:0] RawButtons2,
    input  logic [BTN_W-1:0] RawButtons3,
    input  logic             Ready,
    output logic             Valid,
    output logic [1:0]       Select,
    output logic [BTN_W-1:0] ButtonVector,
    output logic             Overflow
);

    logic [BTN_W-1:0]        w_raw [NUM_CHANNELS];
    logic [BTN_W-1:0]        w_rise [NUM_CHANNELS];
    logic [BTN_W-1:0]        w_stable_unused [NUM_CHANNELS];
    logic [BTN_W-1:0]        r_pending [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] w_req;
    logic [NUM_CHANNELS-1:0] w_clr;
    logic [1:0]              w_pick;
    logic                    w_grant;
    logic [BTN_W-1:0]        w_pick_vec;
    logic                    w_ovf_next;

    state_t                  r_state, w_state_next;
    logic                    r_valid, w_valid_next;
    logic [1:0]              r_sel, w_sel_next;
    logic [BTN_W-1:0]        r_bv, w_bv_next;
    logic [1:0]              r_last, w_last_next;
    logic                    r_ovf;

    assign w_raw[0] = RawButtons1;
    assign w_raw[1] = RawButtons2;
    assign w_raw[2] = RawButtons3;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .Clk     (Clk),
            .Rst     (Rst),
            .i_raw   (w_raw[i]),
            .o_stable(w_stable_unused[i]),
            .o_rise  (w_rise[i])
        );
    end

    always_comb begin
        w_req      = '0;
        w_clr      = '0;
        w_pick_vec = '0;
        w_ovf_next = 1'b0;
        for (int c = 0; c < NUM_CHANNELS; c++) w_req[c] = |r_pending[c];
        w_pick  = rr_pick(r_last, w_req);
        w_grant = (r_state == ST_IDLE) && (w_pick != SEL_NONE);
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            w_clr[c] = w_grant && (w_pick == 2'(c + 1));
            if (w_clr[c]) w_pick_vec = r_pending[c];
            // A rise landing on a set bit that is not being granted this edge is lost.
            if (!w_clr[c] && |(w_rise[c] & r_pending[c])) w_ovf_next = 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_valid_next = r_valid;
        w_sel_next   = r_sel;
        w_bv_next    = r_bv;
        w_last_next  = r_last;
        if (w_grant) begin
            w_state_next = ST_OFFER;
            w_valid_next = 1'b1;
            w_sel_next   = w_pick;
            w_bv_next    = w_pick_vec;
            w_last_next  = w_pick;
        end else if (r_state == ST_OFFER && Ready) begin
            w_state_next = ST_IDLE;
            w_valid_next = 1'b0;
            w_sel_next   = SEL_NONE;
            w_bv_next    = '0;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_sel   <= SEL_NONE;
            r_bv    <= '0;
            r_last  <= SEL_P3;
            r_ovf   <= 1'b0;
            for (int c = 0; c < NUM_CHANNELS; c++) r_pending[c] <= '0;
        end else begin
            r_state <= w_state_next;
            r_valid <= w_valid_next;
            r_sel   <= w_sel_next;
            r_bv    <= w_bv_next;
            r_last  <= w_last_next;
            r_ovf   <= w_ovf_next;
            for (int c = 0; c < NUM_CHANNELS; c++)
                r_pending[c] <= (w_clr[c] ? '0 : r_pending[c]) | w_rise[c];
        end
    end

    assign Valid        = r_valid;
    assign Select       = r_sel;
    assign ButtonVector = r_bv;
    assign Overflow     = r_ovf;

endmodule

// File: tb/tb_button_encoder.sv
// tb_button_encoder: directed checks of reset, latency, round-robin, backpressure/overflow,
// glitch rejection and mid-offer reset with DEBOUNCE_CYCLES=4.
module tb_button_encoder;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic [2:0] RawButtons1 = '0;
    logic [2:0] RawButtons2 = '0;
    logic [2:0] RawButtons3 = '0;
    logic       Ready = 1'b0;
    logic       Valid;
    logic [1:0] Select;
    logic [2:0] ButtonVector;
    logic       Overflow;

    int checks   = 0;
    int failures = 0;

    button_encoder #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .RawButtons1 (RawButtons1),
        .RawButtons2 (RawButtons2),
        .RawButtons3 (RawButtons3),
        .Ready       (Ready),
        .Valid       (Valid),
        .Select      (Select),
        .ButtonVector(ButtonVector),
        .Overflow    (Overflow)
    );

    always #5 Clk = ~Clk;

    task automatic do_reset;
        @(negedge Clk);
        Rst = 1'b0;
        RawButtons1 = '0;
        RawButtons2 = '0;
        RawButtons3 = '0;
        Ready = 1'b0;
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_reset;
        logic seen;
        Rst = 1'b0;
        #1;
        checks++; if (Valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", Valid); end
        checks++; if (Select !== 2'd0) begin failures++; $display("FAIL reset_select got=%0d exp=0", Select); end
        checks++; if (ButtonVector !== 3'b000) begin failures++; $display("FAIL reset_bv got=%b exp=000", ButtonVector); end
        checks++; if (Overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", Overflow); end
        @(negedge Clk);
        Rst = 1'b1;
        seen = 1'b0;
        repeat (100) begin
            @(posedge Clk); #1;
            if (Valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL reset_idle_valid got=%b exp=0", seen); end
    endtask

    task automatic test_single_press;
        logic exp_v;
        do_reset();
        @(negedge Clk);
        RawButtons2 = 3'b101;
        Ready = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            @(posedge Clk); #1;
            exp_v = (n == 7);
            checks++; if (Valid !== exp_v) begin failures++; $display("FAIL single_valid edge=%0d got=%b exp=%b", n, Valid, exp_v); end
            if (n == 7) begin
                checks++; if (Select !== 2'd2) begin failures++; $display("FAIL single_select got=%0d exp=2", Select); end
                checks++; if (ButtonVector !== 3'b101) begin failures++; $display("FAIL single_bv got=%b exp=101", ButtonVector); end
            end
            if (n == 8) begin
                checks++; if (Select !== 2'd0) begin failures++; $display("FAIL single_select_clr got=%0d exp=0", Select); end
                checks++; if (ButtonVector !== 3'b000) begin failures++; $display("FAIL single_bv_clr got=%b exp=000", ButtonVector); end
            end
        end
    endtask

    task automatic test_round_robin;
        logic exp_v;
        do_reset();
        Ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            @(negedge Clk);
            RawButtons1 = 3'b001;
            RawButtons3 = 3'b001;
            for (int n = 1; n <= 10; n++) begin
                @(posedge Clk); #1;
                exp_v = (n == 7) || (n == 9);
                checks++; if (Valid !== exp_v) begin failures++; $display("FAIL rr_valid round=%0d edge=%0d got=%b exp=%b", r, n, Valid, exp_v); end
                if (n == 7) begin
                    checks++; if (Select !== 2'd1) begin failures++; $display("FAIL rr_first round=%0d got=%0d exp=1", r, Select); end
                end
                if (n == 9) begin
                    checks++; if (Select !== 2'd3) begin failures++; $display("FAIL rr_second round=%0d got=%0d exp=3", r, Select); end
                end
            end
            @(negedge Clk);
            RawButtons1 = '0;
            RawButtons3 = '0;
            repeat (10) @(negedge Clk);
        end
    endtask

    task automatic test_back_to_back;
        int   k;
        int   ovf;
        logic hold_bad;
        do_reset();
        @(negedge Clk);
        RawButtons1 = 3'b001;
        k = 0;
        while (!Valid && k < 20) begin
            @(posedge Clk); #1;
            k++;
        end
        checks++; if (Valid !== 1'b1) begin failures++; $display("FAIL bp_offer_timeout got=%b exp=1", Valid); end
        ovf = 0;
        hold_bad = 1'b0;
        for (int p = 0; p < 4; p++) begin
            @(negedge Clk);
            RawButtons1 = (p % 2 == 1) ? 3'b001 : 3'b000;
            repeat (10) begin
                @(posedge Clk); #1;
                if (Overflow === 1'b1) ovf++;
                if (!(Valid === 1'b1 && Select === 2'd1 && ButtonVector === 3'b001)) hold_bad = 1'b1;
            end
            if (p == 1) begin
                checks++; if (ovf !== 0) begin failures++; $display("FAIL bp_first_repress_ovf got=%0d exp=0", ovf); end
            end
        end
        checks++; if (hold_bad !== 1'b0) begin failures++; $display("FAIL bp_hold_stable got=%b exp=0", hold_bad); end
        checks++; if (ovf !== 1) begin failures++; $display("FAIL bp_overflow_pulses got=%0d exp=1", ovf); end
        @(negedge Clk);
        Ready = 1'b1;
        @(posedge Clk); #1;
        checks++; if (Valid !== 1'b0) begin failures++; $display("FAIL bp_accept got=%b exp=0", Valid); end
        @(posedge Clk); #1;
        checks++; if (Valid !== 1'b1) begin failures++; $display("FAIL bp_next_valid got=%b exp=1", Valid); end
        checks++; if (Select !== 2'd1) begin failures++; $display("FAIL bp_next_select got=%0d exp=1", Select); end
        checks++; if (ButtonVector !== 3'b001) begin failures++; $display("FAIL bp_next_bv got=%b exp=001", ButtonVector); end
    endtask

    task automatic test_glitch;
        logic seen_v;
        logic seen_o;
        do_reset();
        Ready = 1'b1;
        @(negedge Clk);
        RawButtons1 = 3'b010;
        repeat (3) @(negedge Clk);
        RawButtons1 = 3'b000;
        seen_v = 1'b0;
        seen_o = 1'b0;
        repeat (20) begin
            @(posedge Clk); #1;
            if (Valid) seen_v = 1'b1;
            if (Overflow) seen_o = 1'b1;
        end
        checks++; if (seen_v !== 1'b0) begin failures++; $display("FAIL glitch_valid got=%b exp=0", seen_v); end
        checks++; if (seen_o !== 1'b0) begin failures++; $display("FAIL glitch_overflow got=%b exp=0", seen_o); end
    endtask

    task automatic test_reset_mid;
        int   k;
        logic seen;
        do_reset();
        @(negedge Clk);
        RawButtons1 = 3'b001;
        RawButtons2 = 3'b001;
        k = 0;
        while (!Valid && k < 20) begin
            @(posedge Clk); #1;
            k++;
        end
        checks++; if (Select !== 2'd1 || Valid !== 1'b1) begin failures++; $display("FAIL mid_offer got=%b/%0d exp=1/1", Valid, Select); end
        @(posedge Clk); #2;
        Rst = 1'b0;
        #1;
        checks++; if (Valid !== 1'b0) begin failures++; $display("FAIL mid_async_valid got=%b exp=0", Valid); end
        checks++; if (Select !== 2'd0) begin failures++; $display("FAIL mid_async_select got=%0d exp=0", Select); end
        checks++; if (ButtonVector !== 3'b000) begin failures++; $display("FAIL mid_async_bv got=%b exp=000", ButtonVector); end
        RawButtons1 = '0;
        RawButtons2 = '0;
        @(negedge Clk);
        Rst = 1'b1;
        Ready = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(posedge Clk); #1;
            if (Valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mid_no_replay got=%b exp=0", seen); end
        @(negedge Clk);
        RawButtons3 = 3'b100;
        k = 0;
        while (!Valid && k < 20) begin
            @(posedge Clk); #1;
            k++;
        end
        checks++; if (Valid !== 1'b1) begin failures++; $display("FAIL mid_fresh_valid got=%b exp=1", Valid); end
        checks++; if (Select !== 2'd3) begin failures++; $display("FAIL mid_fresh_select got=%0d exp=3", Select); end
        checks++; if (ButtonVector !== 3'b100) begin failures++; $display("FAIL mid_fresh_bv got=%b exp=100", ButtonVector); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_round_robin();
        test_back_to_back();
        test_glitch();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
